// File: rtl/regfile_param_if.sv
// Register file bus: rs1/rs2 reads, rd writeback, bulk clear, debug read.
// master = decode/WB pipeline side, slave = register file side.
interface regfile_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] i_rs1_addr;
    logic [ADDR_W-1:0] i_rs2_addr;
    logic [DATA_W-1:0] o_rs1_data;
    logic [DATA_W-1:0] o_rs2_data;
    logic [ADDR_W-1:0] i_rd_addr;
    logic [DATA_W-1:0] i_rd_data;
    logic              i_rd_wren;
    logic              i_clr_req;
    logic              o_clr_busy;
    logic              o_clr_done;
    logic [ADDR_W-1:0] i_dbg_addr;
    logic [DATA_W-1:0] o_dbg_data;

    modport master (
        output i_rs1_addr, i_rs2_addr,
        output i_rd_addr, i_rd_data, i_rd_wren,
        output i_clr_req, i_dbg_addr,
        input  o_rs1_data, o_rs2_data,
        input  o_clr_busy, o_clr_done, o_dbg_data
    );

    modport slave (
        input  i_rs1_addr, i_rs2_addr,
        input  i_rd_addr, i_rd_data, i_rd_wren,
        input  i_clr_req, i_dbg_addr,
        output o_rs1_data, o_rs2_data,
        output o_clr_busy, o_clr_done, o_dbg_data
    );
endinterface

// File: rtl/regfile_param.sv
// Parametrised RV32I register file with bulk-clear engine and debug port.
// Ports: i_clk, i_rst_n (async low), bus (regfile_param_if.slave):
//   rs1/rs2 comb reads, rd write, clr_req/busy/done, dbg read.
// Optional same-cycle write bypass: define REGFILE_BYPASS_EN.
module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    regfile_param_if.slave bus
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic [DATA_W-1:0] r_mem [NUM_REGS];

    logic              w_wr_ok;
    logic [DATA_W-1:0] w_rs1;
    logic [DATA_W-1:0] w_rs2;
    logic [DATA_W-1:0] w_dbg;

    // Writes only land while idle; entry 0 is read-only when hard-wired.
    assign w_wr_ok = bus.i_rd_wren && (r_state == S_IDLE) &&
                     !((ZERO_REG != 0) && (bus.i_rd_addr == '0));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        unique case (r_state)
            S_IDLE: begin
                if (bus.i_clr_req) begin
                    w_state_nxt = S_CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            S_CLEAR: begin
                // Pointer wraps back to 0 on the last entry.
                w_ptr_nxt = r_ptr + 1'b1;
                if (&r_ptr) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (r_state == S_CLEAR) begin
            r_mem[r_ptr] <= '0;
        end else if (w_wr_ok) begin
            r_mem[bus.i_rd_addr] <= bus.i_rd_data;
        end
    end

    always_comb begin
        w_rs1 = r_mem[bus.i_rs1_addr];
        w_rs2 = r_mem[bus.i_rs2_addr];
        w_dbg = r_mem[bus.i_dbg_addr];
`ifdef REGFILE_BYPASS_EN
        if (w_wr_ok && (bus.i_rs1_addr == bus.i_rd_addr)) begin
            w_rs1 = bus.i_rd_data;
        end
        if (w_wr_ok && (bus.i_rs2_addr == bus.i_rd_addr)) begin
            w_rs2 = bus.i_rd_data;
        end
`endif
        if (ZERO_REG != 0) begin
            if (bus.i_rs1_addr == '0) w_rs1 = '0;
            if (bus.i_rs2_addr == '0) w_rs2 = '0;
            if (bus.i_dbg_addr == '0) w_dbg = '0;
        end
    end

    assign bus.o_rs1_data = w_rs1;
    assign bus.o_rs2_data = w_rs2;
    assign bus.o_dbg_data = w_dbg;
    assign bus.o_clr_busy = (r_state == S_CLEAR);
    assign bus.o_clr_done = (r_state == S_DONE);
endmodule

// File: tb/tb_regfile_param.sv
// Directed testbench for regfile_param.
// Two instances: 32x32 with x0 hard-wired, 8x64 with x0 writable.
module tb_regfile_param;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    regfile_param_if #(.DATA_W(32), .ADDR_W(5)) b0 ();
    regfile_param_if #(.DATA_W(64), .ADDR_W(3)) b1 ();

    regfile_param #(
        .DATA_W(32), .ADDR_W(5), .ZERO_REG(1)
    ) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(b0.slave)
    );

    regfile_param #(
        .DATA_W(64), .ADDR_W(3), .ZERO_REG(0)
    ) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(b1.slave)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        b0.i_rs1_addr = '0; b0.i_rs2_addr = '0;
        b0.i_rd_addr  = '0; b0.i_rd_data  = '0;
        b0.i_rd_wren  = 0;  b0.i_clr_req  = 0;
        b0.i_dbg_addr = '0;
        b1.i_rs1_addr = '0; b1.i_rs2_addr = '0;
        b1.i_rd_addr  = '0; b1.i_rd_data  = '0;
        b1.i_rd_wren  = 0;  b1.i_clr_req  = 0;
        b1.i_dbg_addr = '0;
    endtask

    task automatic test_reset;
        rst_n = 0;
        idle_inputs();
        step();
        step();
        checks++;
        if (b0.o_clr_busy !== 1'b0 || b0.o_clr_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_flags0: busy=%b done=%b want 0 0",
                     b0.o_clr_busy, b0.o_clr_done);
        end
        checks++;
        if (b1.o_clr_busy !== 1'b0 || b1.o_clr_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_flags1: busy=%b done=%b want 0 0",
                     b1.o_clr_busy, b1.o_clr_done);
        end
        rst_n = 1;
        step();
        for (int i = 0; i < 32; i++) begin
            b0.i_rs1_addr = 5'(i);
            b0.i_rs2_addr = 5'(31 - i);
            b0.i_dbg_addr = 5'(i);
            #1;
            checks++;
            if (b0.o_rs1_data !== 32'h0 || b0.o_rs2_data !== 32'h0 ||
                b0.o_dbg_data !== 32'h0) begin
                errors++;
                $display("FAIL rst_read0[%0d]: %h %h %h want 0",
                         i, b0.o_rs1_data, b0.o_rs2_data, b0.o_dbg_data);
            end
        end
        for (int i = 0; i < 8; i++) begin
            b1.i_rs1_addr = 3'(i);
            b1.i_rs2_addr = 3'(7 - i);
            b1.i_dbg_addr = 3'(i);
            #1;
            checks++;
            if (b1.o_rs1_data !== 64'h0 || b1.o_rs2_data !== 64'h0 ||
                b1.o_dbg_data !== 64'h0) begin
                errors++;
                $display("FAIL rst_read1[%0d]: %h %h %h want 0",
                         i, b1.o_rs1_data, b1.o_rs2_data, b1.o_dbg_data);
            end
        end
    endtask

    task automatic test_bypass;
        logic [31:0] exp;
`ifdef REGFILE_BYPASS_EN
        exp = 32'hDEADBEEF;
`else
        exp = 32'h0;
`endif
        b0.i_rd_addr  = 5'd5;
        b0.i_rd_data  = 32'hDEADBEEF;
        b0.i_rd_wren  = 1;
        b0.i_rs1_addr = 5'd5;
        b0.i_dbg_addr = 5'd5;
        #1;
        checks++;
        if (b0.o_rs1_data !== exp) begin
            errors++;
            $display("FAIL bypass_same: got %h want %h",
                     b0.o_rs1_data, exp);
        end
        checks++;
        if (b0.o_dbg_data !== 32'h0) begin
            errors++;
            $display("FAIL dbg_no_bypass: got %h want 0",
                     b0.o_dbg_data);
        end
        step();
        b0.i_rd_wren = 0;
        #1;
        checks++;
        if (b0.o_rs1_data !== 32'hDEADBEEF ||
            b0.o_dbg_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_next: rs1=%h dbg=%h want deadbeef",
                     b0.o_rs1_data, b0.o_dbg_data);
        end
    endtask

    task automatic test_zero_reg;
        logic [63:0] exp1;
        b0.i_rd_addr  = 5'd0;
        b0.i_rd_data  = 32'h12345678;
        b0.i_rd_wren  = 1;
        b0.i_rs1_addr = 5'd0;
        b0.i_rs2_addr = 5'd0;
        b0.i_dbg_addr = 5'd0;
        #1;
        checks++;
        if (b0.o_rs1_data !== 32'h0) begin
            errors++;
            $display("FAIL x0_bypass: got %h want 0", b0.o_rs1_data);
        end
        step();
        b0.i_rd_wren = 0;
        #1;
        checks++;
        if (b0.o_rs1_data !== 32'h0 || b0.o_rs2_data !== 32'h0 ||
            b0.o_dbg_data !== 32'h0) begin
            errors++;
            $display("FAIL x0_zero: %h %h %h want 0",
                     b0.o_rs1_data, b0.o_rs2_data, b0.o_dbg_data);
        end
`ifdef REGFILE_BYPASS_EN
        exp1 = 64'h12345678;
`else
        exp1 = 64'h0;
`endif
        b1.i_rd_addr  = 3'd0;
        b1.i_rd_data  = 64'h12345678;
        b1.i_rd_wren  = 1;
        b1.i_rs1_addr = 3'd0;
        b1.i_dbg_addr = 3'd0;
        #1;
        checks++;
        if (b1.o_rs1_data !== exp1) begin
            errors++;
            $display("FAIL x0_ord_bypass: got %h want %h",
                     b1.o_rs1_data, exp1);
        end
        step();
        b1.i_rd_wren = 0;
        #1;
        checks++;
        if (b1.o_rs1_data !== 64'h12345678 ||
            b1.o_dbg_data !== 64'h12345678) begin
            errors++;
            $display("FAIL x0_ord: rs1=%h dbg=%h want 12345678",
                     b1.o_rs1_data, b1.o_dbg_data);
        end
    endtask

    task automatic test_clear;
        logic [31:0] exp7;
        for (int i = 1; i < 32; i++) begin
            b0.i_rd_addr = 5'(i);
            b0.i_rd_data = 32'(i);
            b0.i_rd_wren = 1;
            step();
        end
        b0.i_rd_wren  = 0;
        b0.i_dbg_addr = 5'd7;
        #1;
        checks++;
        if (b0.o_dbg_data !== 32'd7) begin
            errors++;
            $display("FAIL fill_x7: got %h want 7", b0.o_dbg_data);
        end
        b0.i_clr_req = 1;
        step();
        b0.i_clr_req = 0;
        for (int k = 0; k < 32; k++) begin
            exp7 = (k >= 8) ? 32'd0 : 32'd7;
            checks++;
            if (b0.o_clr_busy !== 1'b1 || b0.o_clr_done !== 1'b0) begin
                errors++;
                $display("FAIL clr_busy[%0d]: busy=%b done=%b want 1 0",
                         k, b0.o_clr_busy, b0.o_clr_done);
            end
            checks++;
            if (b0.o_dbg_data !== exp7) begin
                errors++;
                $display("FAIL clr_x7[%0d]: got %h want %h",
                         k, b0.o_dbg_data, exp7);
            end
            if (k == 4) begin
                b0.i_rd_addr = 5'd3;
                b0.i_rd_data = 32'h33;
                b0.i_rd_wren = 1;
            end
            if (k == 5) b0.i_rd_wren = 0;
            step();
        end
        checks++;
        if (b0.o_clr_busy !== 1'b0 || b0.o_clr_done !== 1'b1) begin
            errors++;
            $display("FAIL clr_done: busy=%b done=%b want 0 1",
                     b0.o_clr_busy, b0.o_clr_done);
        end
        b0.i_rd_addr = 5'd9;
        b0.i_rd_data = 32'h99;
        b0.i_rd_wren = 1;
        step();
        b0.i_dbg_addr = 5'd9;
        #1;
        checks++;
        if (b0.o_clr_done !== 1'b0 || b0.o_dbg_data !== 32'h0) begin
            errors++;
            $display("FAIL done_drop: done=%b x9=%h want 0 0",
                     b0.o_clr_done, b0.o_dbg_data);
        end
        b0.i_rd_addr = 5'd10;
        b0.i_rd_data = 32'hAA;
        step();
        b0.i_rd_wren  = 0;
        b0.i_dbg_addr = 5'd10;
        #1;
        checks++;
        if (b0.o_dbg_data !== 32'hAA) begin
            errors++;
            $display("FAIL first_write: got %h want aa", b0.o_dbg_data);
        end
        for (int i = 0; i < 32; i++) begin
            if (i != 10) begin
                b0.i_rs1_addr = 5'(i);
                #1;
                checks++;
                if (b0.o_rs1_data !== 32'h0) begin
                    errors++;
                    $display("FAIL cleared[%0d]: got %h want 0",
                             i, b0.o_rs1_data);
                end
            end
        end
    endtask

    task automatic test_simul;
        int n;
        b0.i_rd_addr = 5'd4;
        b0.i_rd_data = 32'h44;
        b0.i_rd_wren = 1;
        b0.i_clr_req = 1;
        step();
        b0.i_rd_wren  = 0;
        b0.i_clr_req  = 0;
        b0.i_dbg_addr = 5'd4;
        #1;
        checks++;
        if (b0.o_dbg_data !== 32'h44 || b0.o_clr_busy !== 1'b1) begin
            errors++;
            $display("FAIL simul_start: x4=%h busy=%b want 44 1",
                     b0.o_dbg_data, b0.o_clr_busy);
        end
        n = 0;
        while (b0.o_clr_done !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (b0.o_clr_done !== 1'b1) begin
            errors++;
            $display("FAIL simul_timeout: done=%b want 1",
                     b0.o_clr_done);
        end
        b0.i_rs1_addr = 5'd10;
        #1;
        checks++;
        if (b0.o_dbg_data !== 32'h0 || b0.o_rs1_data !== 32'h0) begin
            errors++;
            $display("FAIL simul_end: x4=%h x10=%h want 0 0",
                     b0.o_dbg_data, b0.o_rs1_data);
        end
        step();
    endtask

    task automatic test_rst_mid_clear;
        int n;
        int cnt;
        b0.i_rd_addr = 5'd20;
        b0.i_rd_data = 32'h20;
        b0.i_rd_wren = 1;
        step();
        b0.i_rd_wren = 0;
        b0.i_clr_req = 1;
        step();
        b0.i_clr_req = 0;
        repeat (10) step();
        b0.i_dbg_addr = 5'd20;
        #1;
        checks++;
        if (b0.o_clr_busy !== 1'b1 || b0.o_dbg_data !== 32'h20) begin
            errors++;
            $display("FAIL pre_abort: busy=%b x20=%h want 1 20",
                     b0.o_clr_busy, b0.o_dbg_data);
        end
        rst_n = 0;
        #1;
        checks++;
        if (b0.o_clr_busy !== 1'b0 || b0.o_clr_done !== 1'b0 ||
            b0.o_dbg_data !== 32'h0) begin
            errors++;
            $display("FAIL abort: busy=%b done=%b x20=%h want 0 0 0",
                     b0.o_clr_busy, b0.o_clr_done, b0.o_dbg_data);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (b0.o_clr_done !== 1'b0) begin
                errors++;
                $display("FAIL abort_done[%0d]: got %b want 0",
                         i, b0.o_clr_done);
            end
        end
        rst_n = 1;
        step();
        b0.i_rd_wren = 1;
        step();
        b0.i_rd_wren = 0;
        b0.i_clr_req = 1;
        step();
        b0.i_clr_req = 0;
        cnt = 0;
        n = 0;
        while (b0.o_clr_busy === 1'b1 && n < 100) begin
            cnt++;
            step();
            n++;
        end
        checks++;
        if (cnt != 32 || b0.o_clr_done !== 1'b1) begin
            errors++;
            $display("FAIL reclear: busy_cycles=%0d done=%b want 32 1",
                     cnt, b0.o_clr_done);
        end
        step();
        checks++;
        if (b0.o_clr_done !== 1'b0 || b0.o_dbg_data !== 32'h0) begin
            errors++;
            $display("FAIL reclear_end: done=%b x20=%h want 0 0",
                     b0.o_clr_done, b0.o_dbg_data);
        end
    endtask

    task automatic test_wide;
        int n;
        int cnt;
        b1.i_rd_addr  = 3'd7;
        b1.i_rd_data  = 64'hFFFF_0000_FFFF_0000;
        b1.i_rd_wren  = 1;
        step();
        b1.i_rd_wren  = 0;
        b1.i_rs2_addr = 3'd7;
        #1;
        checks++;
        if (b1.o_rs2_data !== 64'hFFFF_0000_FFFF_0000) begin
            errors++;
            $display("FAIL wide_rd: got %h want ffff0000ffff0000",
                     b1.o_rs2_data);
        end
        b1.i_clr_req = 1;
        step();
        b1.i_clr_req = 0;
        cnt = 0;
        n = 0;
        while (b1.o_clr_busy === 1'b1 && n < 50) begin
            cnt++;
            step();
            n++;
        end
        checks++;
        if (cnt != 8 || b1.o_clr_done !== 1'b1) begin
            errors++;
            $display("FAIL wide_clr: busy_cycles=%0d done=%b want 8 1",
                     cnt, b1.o_clr_done);
        end
        checks++;
        if (b1.o_rs2_data !== 64'h0) begin
            errors++;
            $display("FAIL wide_cleared: got %h want 0", b1.o_rs2_data);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_zero_reg();
        test_clear();
        test_simul();
        test_rst_mid_clear();
        test_wide();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
